// File: rtl/el2_lsu_clken_gen.sv
// el2_lsu_clken_gen
// Clock-enable generator for the LSU. Each activity channel yields a
// single-pulse enable (c1) and a hold-stretched enable (c2). The block also
// produces a free-running enable with idle hysteresis. Bus-synchronous
// channels are qualified by bus_clk_en, and their requests are held pending
// until the next bus tick. Only enables are produced here; the parent owns
// the clock headers.
module el2_lsu_clken_gen #(
  parameter int                 NUM_CH    = 4,
  parameter int                 HOLD_CYC  = 1,
  parameter int                 IDLE_HOLD = 2,
  parameter logic [NUM_CH-1:0]  BUS_MASK  = (NUM_CH)'(4'b1000)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              clk_override,
  input  logic              dec_tlu_force_halt,
  input  logic              bus_clk_en,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] c1_en,
  output logic [NUM_CH-1:0] c2_en,
  output logic              free_en,
  output logic              lsu_idle
);

  // Counter widths. They are never narrower than one bit, so a zero hold
  // parameter still gives a legal, constant-zero register.
  localparam int HW = (HOLD_CYC  > 0) ? $clog2(HOLD_CYC  + 1) : 1;
  localparam int IW = (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;

  logic [NUM_CH-1:0]         r_pend;
  logic [NUM_CH-1:0][HW-1:0] r_hold_cnt;
  logic [IW-1:0]             r_idle_cnt;
  logic                      r_lsu_idle;

  logic [NUM_CH-1:0]         w_q;
  logic [NUM_CH-1:0]         w_act;
  logic [NUM_CH-1:0]         w_c1;
  logic [NUM_CH-1:0]         w_hold_nz;
  logic [NUM_CH-1:0]         w_pend_nxt;
  logic [NUM_CH-1:0][HW-1:0] w_hold_nxt;
  logic [IW-1:0]             w_idle_nxt;
  logic                      w_any_act;
  logic                      w_free;

  // Per-channel qualifier, activity and single-pulse enable.
  always_comb begin
    w_q   = ~BUS_MASK | {NUM_CH{bus_clk_en}};
    w_act = req | r_pend;
    w_c1  = (w_act | {NUM_CH{clk_override}}) & w_q;
  end

  // Pending bus requests wait for the next tick. A tick consumes them, and
  // force_halt discards them. Non-bus channels never hold a pending request.
  always_comb begin
    if (dec_tlu_force_halt || bus_clk_en) begin
      w_pend_nxt = '0;
    end else begin
      w_pend_nxt = (r_pend | req) & BUS_MASK;
    end
  end

  // Hold counters. Qualified activity retriggers the load, and qualified idle
  // cycles count down. clk_override does not load the counters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    w_hold_nxt = r_hold_cnt;
    w_hold_nz  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hold_nz[i] = (r_hold_cnt[i] != '0);
      if (w_q[i] && w_act[i]) begin
        w_hold_nxt[i] = HW'(HOLD_CYC);
      end else if (w_q[i] && w_hold_nz[i]) begin
        w_hold_nxt[i] = r_hold_cnt[i] - HW'(1);
      end
    end
  end

  // Block-level activity, idle hysteresis counter and free enable.
  always_comb begin
    w_any_act = (|req) | (|busy) | (|r_pend);
    if (w_any_act) begin
      w_idle_nxt = IW'(IDLE_HOLD);
    end else if (r_idle_cnt != '0) begin
      w_idle_nxt = r_idle_cnt - IW'(1);
    end else begin
      w_idle_nxt = r_idle_cnt;
    end
    w_free = w_any_act | (r_idle_cnt != '0) | clk_override | dec_tlu_force_halt;
  end

  // State registers. Reset clears all stretch state and reports the block idle.
  always_ff @(posedge clk or negedge rst_l) begin
    // NOTE: the reset branch covers every register here, so an asserted
    // reset drops c2_en and free_en stretch in the same cycle.
    if (!rst_l) begin
      r_pend     <= '0;
      r_hold_cnt <= '0;
      r_idle_cnt <= '0;
      r_lsu_idle <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the pre-edge values.
      r_pend     <= w_pend_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_lsu_idle <= ~w_free;
    end
  end

  // Output drive.
  always_comb begin
    c1_en    = w_c1;
    c2_en    = w_c1 | (w_hold_nz & w_q) | {NUM_CH{dec_tlu_force_halt}};
    free_en  = w_free;
    lsu_idle = r_lsu_idle;
  end

endmodule
